// File: rtl/bitmap_dot_writer_if.sv
// Write port bundle from bitmap_dot_writer to the bitmap RAM.
// master: the writer drives strobe, address, data and its busy flag.
// slave : the RAM side (or an observer) samples them.
`timescale 1ns/1ps
interface bitmap_dot_writer_if #(
  parameter int AW = 14
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  modport master (output wr_en, wr_addr, wr_data, busy);
  modport slave  (input  wr_en, wr_addr, wr_data, busy);
endinterface

// File: rtl/bitmap_dot_writer.sv
// bitmap_dot_writer: write-side stage for the bitmap RAM read by bitmap_gen.
// Clears the whole bitmap, then on every frame tick moves a bouncing dot by
// one pixel per axis and writes it (colour from sw[2:0], RGB332).
// A debounced btn press clears the screen again and restarts the dot.
// Optional feature macro: BITMAP_TRAIL_EN -- skip the erase write so the dot
// leaves a trail (one write per frame instead of two).
`timescale 1ns/1ps
module bitmap_dot_writer #(
  parameter int   BMP_XW    = 7,
  parameter int   BMP_YW    = 7,
  parameter int   DB_CYCLES = 800000,
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn,
  input  logic [2:0]          sw,
  input  logic                vsync,
  bitmap_dot_writer_if.master wr
);

  localparam int AW  = BMP_XW + BMP_YW;
  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  localparam logic [AW-1:0]     LAST_ADDR = '1;
  localparam logic [BMP_XW-1:0] X_MAX     = '1;
  localparam logic [BMP_YW-1:0] Y_MAX     = '1;
  localparam logic [DBW-1:0]    DB_LAST   = DBW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    WAIT  = 3'd1,
    ERASE = 3'd2,
    MOVE  = 3'd3,
    DRAW  = 3'd4
  } state_t;

  // RGB332 expansion of the 3-bit switch colour: each switch fills one field.
  function automatic logic [7:0] colour(input logic [2:0] s);
    return {{3{s[2]}}, {3{s[1]}}, {2{s[0]}}};
  endfunction

  // One bounce step on the x axis; returns {forward, new position}.
  function automatic logic [BMP_XW:0] step_x(input logic fwd,
                                             input logic [BMP_XW-1:0] pos);
    logic [BMP_XW:0] r;
    if (fwd && pos == X_MAX)       r = {1'b0, X_MAX - BMP_XW'(1)};
    else if (!fwd && pos == '0)    r = {1'b1, BMP_XW'(1)};
    else if (fwd)                  r = {1'b1, pos + BMP_XW'(1)};
    else                           r = {1'b0, pos - BMP_XW'(1)};
    return r;
  endfunction

  // One bounce step on the y axis; returns {forward, new position}.
  function automatic logic [BMP_YW:0] step_y(input logic fwd,
                                             input logic [BMP_YW-1:0] pos);
    logic [BMP_YW:0] r;
    if (fwd && pos == Y_MAX)       r = {1'b0, Y_MAX - BMP_YW'(1)};
    else if (!fwd && pos == '0)    r = {1'b1, BMP_YW'(1)};
    else if (fwd)                  r = {1'b1, pos + BMP_YW'(1)};
    else                           r = {1'b0, pos - BMP_YW'(1)};
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------
  logic vsync_d;
  logic tick;

  // Registered edge detect: tick pulses once when vsync enters its active level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= ~VSYNC_ACT;
      tick    <= 1'b0;
    end else begin
      vsync_d <= vsync;
      tick    <= (vsync == VSYNC_ACT) && (vsync_d != VSYNC_ACT);
    end
  end

  // ---------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------
  logic           btn_s1;
  logic           btn_s2;
  logic [DBW-1:0] db_cnt;
  logic           btn_stable;
  logic           btn_stable_d;
  logic           press;

  // Two-flop synchroniser, then a level that only follows the synced input
  // after it has differed from it for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      db_cnt       <= '0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
    end else begin
      btn_s1       <= btn;
      btn_s2       <= btn_s1;
      btn_stable_d <= btn_stable;
      if (btn_s2 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_s2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign press = btn_stable & ~btn_stable_d;

  // ---------------------------------------------------------------------
  // Control FSM with registered write port
  // ---------------------------------------------------------------------
  state_t              state,   state_n;
  logic [AW-1:0]       cnt,     cnt_n;
  logic [BMP_XW-1:0]   x,       x_n;
  logic [BMP_YW-1:0]   y,       y_n;
  logic                dx,      dx_n;
  logic                dy,      dy_n;
  logic                wr_en_r, wr_en_n;
  logic [AW-1:0]       addr_r,  addr_n;
  logic [7:0]          data_r,  data_n;
  logic                busy_r,  busy_n;
  logic                clearing;

  // Next-state and next-output decode. Each state's write is issued on the
  // edge that leaves it, so the port shows it during the following cycle.
  // A press in WAIT issues clear address 0 on the same edge, which keeps busy
  // one cycle behind the debounced press.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    x_n      = x;
    y_n      = y;
    dx_n     = dx;
    dy_n     = dy;
    wr_en_n  = 1'b0;
    addr_n   = addr_r;
    data_n   = data_r;
    busy_n   = 1'b0;
    clearing = (state == CLEAR) || (state == WAIT && press);

    if (clearing) begin
      wr_en_n = 1'b1;
      addr_n  = cnt;
      data_n  = 8'h00;
      busy_n  = 1'b1;
      if (cnt == LAST_ADDR) begin
        cnt_n   = '0;
        state_n = WAIT;
      end else begin
        cnt_n   = cnt + AW'(1);
        state_n = CLEAR;
      end
      if (state == WAIT) begin
        x_n  = '0;
        y_n  = '0;
        dx_n = 1'b1;
        dy_n = 1'b1;
      end
    end else begin
      case (state)
        WAIT: begin
          if (tick) begin
`ifdef BITMAP_TRAIL_EN
            state_n = MOVE;
`else
            state_n = ERASE;
`endif
          end
        end
        ERASE: begin
          wr_en_n = 1'b1;
          addr_n  = {y, x};
          data_n  = 8'h00;
          state_n = MOVE;
        end
        MOVE: begin
          {dx_n, x_n} = step_x(dx, x);
          {dy_n, y_n} = step_y(dy, y);
          state_n     = DRAW;
        end
        DRAW: begin
          wr_en_n = 1'b1;
          addr_n  = {y, x};
          data_n  = colour(sw);
          state_n = WAIT;
        end
        default: begin
          state_n = CLEAR;
        end
      endcase
    end
  end

  // State, dot position and write port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      dx      <= 1'b1;
      dy      <= 1'b1;
      wr_en_r <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      x       <= x_n;
      y       <= y_n;
      dx      <= dx_n;
      dy      <= dy_n;
      wr_en_r <= wr_en_n;
      addr_r  <= addr_n;
      data_r  <= data_n;
      busy_r  <= busy_n;
    end
  end

  assign wr.wr_en   = wr_en_r;
  assign wr.wr_addr = addr_r;
  assign wr.wr_data = data_r;
  assign wr.busy    = busy_r;

endmodule

// File: tb/tb_bitmap_dot_writer.sv
// Directed bench for bitmap_dot_writer (128x128 bitmap, DB_CYCLES = 16).
// Frame behaviour is driven from a table of hand-computed dot writes;
// clear, debounce, dropped tick and mid-clear reset are hand-written sequences.
`timescale 1ns/1ps
module tb_bitmap_dot_writer;

`ifdef BITMAP_TRAIL_EN
  localparam int WRITES_PER_FRAME = 1;
`else
  localparam int WRITES_PER_FRAME = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic [2:0] sw;
  logic       vsync;

  bitmap_dot_writer_if #(.AW(14)) bus ();

  bitmap_dot_writer #(
    .BMP_XW    (7),
    .BMP_YW    (7),
    .DB_CYCLES (16),
    .VSYNC_ACT (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .sw    (sw),
    .vsync (vsync),
    .wr    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          skip;
    logic [2:0]  swv;
    logic [13:0] erase;
    logic [13:0] draw;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl [6];

  int checks = 0;
  int errors = 0;

  logic [13:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  int          wq_cyc  [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vsync pulse; records every write seen in the following 20 cycles.
  task automatic run_frame(input logic [2:0] s);
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    sw    = s;
    vsync = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 3) vsync = 1'b1;
      if (bus.wr_en === 1'b1) begin
        wq_addr.push_back(bus.wr_addr);
        wq_data.push_back(bus.wr_data);
        wq_cyc.push_back(c);
      end
    end
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    for (int f = 0; f < v.skip; f++) run_frame(v.swv);
    run_frame(v.swv);
    check({tag, "_nwrites"}, wq_addr.size(), WRITES_PER_FRAME);
    if (wq_addr.size() == WRITES_PER_FRAME) begin
`ifndef BITMAP_TRAIL_EN
      check({tag, "_erase_addr"}, int'(wq_addr[0]), int'(v.erase));
      check({tag, "_erase_data"}, int'(wq_data[0]), 0);
      check({tag, "_gap"}, wq_cyc[1] - wq_cyc[0], 2);
`endif
      check({tag, "_draw_addr"}, int'(wq_addr[WRITES_PER_FRAME-1]), int'(v.draw));
      check({tag, "_draw_data"}, int'(wq_data[WRITES_PER_FRAME-1]), int'(v.data));
    end
  endtask

  // Expects a full 16384-write clear starting now or within 20 cycles.
  task automatic clear_run(input string tag);
    int n;
    int bad;
    n = 0;
    while (bus.wr_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start"}, int'(bus.wr_en), 1);
    bad = 0;
    for (int i = 0; i < 16384; i++) begin
      if (!(bus.wr_en === 1'b1 && bus.wr_addr === 14'(i) &&
            bus.wr_data === 8'h00 && bus.busy === 1'b1)) bad++;
      step();
    end
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_end_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_end_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w;
    int k;
    vec_t post;

    // Frames 1-3, then frames 127-129 around the (127,127) corner.
    tbl[0] = '{0,   3'b101, 14'd0,     14'd129,   8'hE3};
    tbl[1] = '{0,   3'b010, 14'd129,   14'd258,   8'h1C};
    tbl[2] = '{0,   3'b111, 14'd258,   14'd387,   8'hFF};
    tbl[3] = '{123, 3'b001, 14'd16254, 14'd16383, 8'h03};
    tbl[4] = '{0,   3'b110, 14'd16383, 14'd16254, 8'hFC};
    tbl[5] = '{0,   3'b000, 14'd16254, 14'd16125, 8'h00};
    post   = '{0,   3'b101, 14'd0,     14'd129,   8'hE3};

    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = 3'b000;
    vsync = 1'b1;
    repeat (3) step();
    check("rst_wr_en",   int'(bus.wr_en),   0);
    check("rst_wr_addr", int'(bus.wr_addr), 0);
    check("rst_wr_data", int'(bus.wr_data), 0);
    check("rst_busy",    int'(bus.busy),    0);

    rst_n = 1'b1;
    clear_run("init_clear");

    for (int i = 0; i < 6; i++) check_frame(tbl[i], $sformatf("frame_vec%0d", i));

    // Short glitch: must not reach the debounced level.
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    w = 0;
    repeat (40) begin
      step();
      if (bus.busy === 1'b1) w++;
    end
    check("glitch_no_clear", w, 0);

    // Real press: busy 19 cycles after btn rises, full clear, tick during clear dropped.
    btn = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (bus.busy !== 1'b1 && lat < 40);
    check("press_latency", lat, 19);
    fork
      clear_run("press_clear");
      begin
        repeat (21) step();
        btn = 1'b0;
        repeat (200) step();
        vsync = 1'b0;
        repeat (3) step();
        vsync = 1'b1;
      end
    join
    w = 0;
    repeat (30) begin
      step();
      if (bus.wr_en === 1'b1) w++;
    end
    check("tick_in_clear_dropped", w, 0);
    check_frame(post, "after_press");

    // Reset in the middle of a clear.
    btn = 1'b1;
    k = 0;
    while (!(bus.wr_en === 1'b1 && bus.wr_addr === 14'd5000) && k < 20000) begin
      step();
      k++;
      if (k == 40) btn = 1'b0;
    end
    btn = 1'b0;
    check("reached_addr_5000", int'(bus.wr_addr), 5000);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en",   int'(bus.wr_en),   0);
    check("midrst_wr_addr", int'(bus.wr_addr), 0);
    check("midrst_busy",    int'(bus.busy),    0);
    repeat (3) step();
    rst_n = 1'b1;
    clear_run("rst_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
